// File: rtl/tilemap_pkg.sv
// Shared constants and types for the tilemap fetch scheduler and its per-layer mode generator.
package tilemap_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [2:0] B_TRIG     = 3'd0;
  localparam logic [2:0] B_DEADLINE = 3'd3;
  localparam logic [2:0] A_TRIG     = 3'd4;
  localparam logic [2:0] A_DEADLINE = 3'd7;

  localparam logic [2:0] B_LOAD_OFFSET = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ_B = 2'd1,
    ST_REQ_A = 2'd2
  } sched_state_t;

  // Load point wraps within the 8-pixel slot.
  function automatic logic [2:0] load_point(input logic [2:0] scroll, input logic [2:0] offset);
    return scroll + offset;
  endfunction

endpackage

// File: rtl/tilemap_mode_gen.sv
// Per-layer shift-register mode and output-tap flip generator, updated once per pixel clock enable.
module tilemap_mode_gen
  import tilemap_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cen,
  input  logic       i_disp_en,
  input  logic [2:0] i_phase,
  input  logic [2:0] i_load_point,
  input  logic       i_pend_ff,
  output logic [1:0] o_mode,
  output logic       o_ff
);

  logic [1:0] r_mode;
  logic       r_ff;

  // Flip switches on the load cycle itself so the tap and the new word change together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= MODE_HOLD;
      r_ff   <= 1'b0;
    end else if (i_cen) begin
      if (!i_disp_en) begin
        r_mode <= MODE_HOLD;
      end else if (i_phase == i_load_point) begin
        r_mode <= MODE_LOAD;
        r_ff   <= i_pend_ff;
      end else begin
        r_mode <= r_ff ? MODE_SHR : MODE_SHL;
      end
    end
  end

  assign o_mode = r_mode;
  assign o_ff   = r_ff;

endmodule

// File: rtl/tilemap_fetch_sched.sv
// Two-layer tilemap ROM fetch scheduler: one shared ROM port, one fetch per layer per 8-pixel slot.
// Optional saturating abort counter enabled by defining TILEMAP_SCHED_UNDERRUN_CNT_EN.
module tilemap_fetch_sched
  import tilemap_pkg::*;
#(
  parameter int CODE_W = 12,
  parameter int ADDR_W = 15
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_RST_n,
  input  logic              i_EMU_CLK6MPCEN_n,
  input  logic              i_ABS_1H,
  input  logic              i_ABS_2H,
  input  logic              i_ABS_4H,
  input  logic              i_DISP_EN,
  input  logic [CODE_W-1:0] i_A_TILECODE,
  input  logic [CODE_W-1:0] i_B_TILECODE,
  input  logic [2:0]        i_A_ROW,
  input  logic [2:0]        i_B_ROW,
  input  logic              i_A_VFLIP,
  input  logic              i_B_VFLIP,
  input  logic              i_A_HFLIP,
  input  logic              i_B_HFLIP,
  input  logic [2:0]        i_A_HSCROLL,
  input  logic [2:0]        i_B_HSCROLL,
  output logic              o_ROM_REQ,
  output logic [ADDR_W-1:0] o_ROM_ADDR,
  input  logic              i_ROM_ACK,
  input  logic [31:0]       i_ROM_DATA,
  output logic [31:0]       o_GFXDATA,
  output logic [1:0]        o_A_MODE,
  output logic [1:0]        o_B_MODE,
  output logic              o_AFF,
  output logic              o_BFF,
`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
  output logic              o_UNDERRUN,
  input  logic              i_UNDERRUN_CLR,
  output logic [7:0]        o_UNDERRUN_CNT
`else
  output logic              o_UNDERRUN
`endif
);

  sched_state_t      r_state;
  logic              r_rom_req;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [31:0]       r_gfxdata;
  logic              r_underrun;
  logic              r_pend_aff;
  logic              r_pend_bff;

  logic       w_cen;
  logic [2:0] w_phase;
  logic       w_deadline;
  logic       w_abort;
  logic [2:0] w_b_load_point;

  assign w_cen          = ~i_EMU_CLK6MPCEN_n;
  assign w_phase        = {i_ABS_4H, i_ABS_2H, i_ABS_1H};
  assign w_b_load_point = load_point(i_B_HSCROLL, B_LOAD_OFFSET);

  assign w_deadline = w_cen &&
                      (((r_state == ST_REQ_B) && (w_phase == B_DEADLINE)) ||
                       ((r_state == ST_REQ_A) && (w_phase == A_DEADLINE)));
  assign w_abort    = w_deadline && !i_ROM_ACK;

  // An ack coinciding with the deadline takes priority, so the word is still delivered.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      r_state    <= ST_IDLE;
      r_rom_req  <= 1'b0;
      r_rom_addr <= '0;
      r_gfxdata  <= '0;
      r_underrun <= 1'b0;
      r_pend_aff <= 1'b0;
      r_pend_bff <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_cen && i_DISP_EN) begin
            if (w_phase == B_TRIG) begin
              r_state    <= ST_REQ_B;
              r_rom_req  <= 1'b1;
              r_rom_addr <= {i_B_TILECODE, i_B_ROW ^ {3{i_B_VFLIP}}};
              r_pend_bff <= i_B_HFLIP;
            end else if (w_phase == A_TRIG) begin
              r_state    <= ST_REQ_A;
              r_rom_req  <= 1'b1;
              r_rom_addr <= {i_A_TILECODE, i_A_ROW ^ {3{i_A_VFLIP}}};
              r_pend_aff <= i_A_HFLIP;
            end
          end
        end
        ST_REQ_B, ST_REQ_A: begin
          if (i_ROM_ACK) begin
            r_gfxdata <= i_ROM_DATA;
            r_rom_req <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_abort) begin
            r_gfxdata  <= '0;
            r_rom_req  <= 1'b0;
            r_underrun <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_rom_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ROM_REQ  = r_rom_req;
  assign o_ROM_ADDR = r_rom_addr;
  assign o_GFXDATA  = r_gfxdata;
  assign o_UNDERRUN = r_underrun;

  tilemap_mode_gen u_mode_a (
    .i_clk        (i_EMU_MCLK),
    .i_rst_n      (i_EMU_RST_n),
    .i_cen        (w_cen),
    .i_disp_en    (i_DISP_EN),
    .i_phase      (w_phase),
    .i_load_point (i_A_HSCROLL),
    .i_pend_ff    (r_pend_aff),
    .o_mode       (o_A_MODE),
    .o_ff         (o_AFF)
  );

  tilemap_mode_gen u_mode_b (
    .i_clk        (i_EMU_MCLK),
    .i_rst_n      (i_EMU_RST_n),
    .i_cen        (w_cen),
    .i_disp_en    (i_DISP_EN),
    .i_phase      (w_phase),
    .i_load_point (w_b_load_point),
    .i_pend_ff    (r_pend_bff),
    .o_mode       (o_B_MODE),
    .o_ff         (o_BFF)
  );

`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  // Clear beats a same-cycle abort; the count sticks at 255.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      r_underrun_cnt <= 8'd0;
    end else if (i_UNDERRUN_CLR) begin
      r_underrun_cnt <= 8'd0;
    end else if (w_abort && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign o_UNDERRUN_CNT = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_tilemap_fetch_sched.sv
// Directed bench for tilemap_fetch_sched: table-driven slot vectors plus hand-written corner sequences.
module tb_tilemap_fetch_sched;

  logic        i_EMU_MCLK;
  logic        i_EMU_RST_n;
  logic        i_EMU_CLK6MPCEN_n;
  logic        i_ABS_1H, i_ABS_2H, i_ABS_4H;
  logic        i_DISP_EN;
  logic [11:0] i_A_TILECODE, i_B_TILECODE;
  logic [2:0]  i_A_ROW, i_B_ROW;
  logic        i_A_VFLIP, i_B_VFLIP, i_A_HFLIP, i_B_HFLIP;
  logic [2:0]  i_A_HSCROLL, i_B_HSCROLL;
  logic        o_ROM_REQ;
  logic [14:0] o_ROM_ADDR;
  logic        i_ROM_ACK;
  logic [31:0] i_ROM_DATA;
  logic [31:0] o_GFXDATA;
  logic [1:0]  o_A_MODE, o_B_MODE;
  logic        o_AFF, o_BFF;
  logic        o_UNDERRUN;
`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
  logic        i_UNDERRUN_CLR;
  logic [7:0]  o_UNDERRUN_CNT;
`endif

  int   checks;
  int   failures;
  logic [2:0] curP;
  int   reqAge;
  int   ackDelay;
  bit   suppressAck;
  bit   forceAck;

  tilemap_fetch_sched dut (
    .i_EMU_MCLK        (i_EMU_MCLK),
    .i_EMU_RST_n       (i_EMU_RST_n),
    .i_EMU_CLK6MPCEN_n (i_EMU_CLK6MPCEN_n),
    .i_ABS_1H          (i_ABS_1H),
    .i_ABS_2H          (i_ABS_2H),
    .i_ABS_4H          (i_ABS_4H),
    .i_DISP_EN         (i_DISP_EN),
    .i_A_TILECODE      (i_A_TILECODE),
    .i_B_TILECODE      (i_B_TILECODE),
    .i_A_ROW           (i_A_ROW),
    .i_B_ROW           (i_B_ROW),
    .i_A_VFLIP         (i_A_VFLIP),
    .i_B_VFLIP         (i_B_VFLIP),
    .i_A_HFLIP         (i_A_HFLIP),
    .i_B_HFLIP         (i_B_HFLIP),
    .i_A_HSCROLL       (i_A_HSCROLL),
    .i_B_HSCROLL       (i_B_HSCROLL),
    .o_ROM_REQ         (o_ROM_REQ),
    .o_ROM_ADDR        (o_ROM_ADDR),
    .i_ROM_ACK         (i_ROM_ACK),
    .i_ROM_DATA        (i_ROM_DATA),
    .o_GFXDATA         (o_GFXDATA),
    .o_A_MODE          (o_A_MODE),
    .o_B_MODE          (o_B_MODE),
    .o_AFF             (o_AFF),
    .o_BFF             (o_BFF),
`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
    .i_UNDERRUN_CLR    (i_UNDERRUN_CLR),
    .o_UNDERRUN_CNT    (o_UNDERRUN_CNT),
`endif
    .o_UNDERRUN        (o_UNDERRUN)
  );

  initial begin
    i_EMU_MCLK = 1'b0;
    forever #5 i_EMU_MCLK = ~i_EMU_MCLK;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        dispEn;
    logic [2:0]  aScroll, bScroll;
    logic [11:0] aCode, bCode;
    logic [2:0]  aRow, bRow;
    logic [14:0] expAAddr, expBAddr;
    logic [15:0] expAModes, expBModes;
  } vec_t;

  vec_t vecs[4];

  // Distinct line word per ROM address.
  function automatic logic [31:0] romWord(input logic [14:0] a);
    return {1'b1, a, 1'b0, ~a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_DISP_EN    = v.dispEn;
    i_A_HSCROLL  = v.aScroll;
    i_B_HSCROLL  = v.bScroll;
    i_A_TILECODE = v.aCode;
    i_B_TILECODE = v.bCode;
    i_A_ROW      = v.aRow;
    i_B_ROW      = v.bRow;
    i_A_VFLIP = 1'b0; i_B_VFLIP = 1'b0; i_A_HFLIP = 1'b0; i_B_HFLIP = 1'b0;
  endtask

  // One MCLK: drive phase/CEN and the ROM responder, then sample 1 ns after the edge.
  task automatic tick(input bit cen);
    i_EMU_CLK6MPCEN_n = ~cen;
    {i_ABS_4H, i_ABS_2H, i_ABS_1H} = curP;
    if (o_ROM_REQ) reqAge++; else reqAge = 0;
    i_ROM_ACK  = forceAck | (o_ROM_REQ & ~suppressAck & (reqAge == ackDelay));
    i_ROM_DATA = romWord(o_ROM_ADDR);
    @(posedge i_EMU_MCLK);
    #1;
  endtask

  task automatic pixel();
    repeat (3) tick(1'b0);
    tick(1'b1);
    curP++;
  endtask

  initial begin
    checks = 0; failures = 0; curP = 3'd0; reqAge = 0; ackDelay = 3;
    suppressAck = 1'b0; forceAck = 1'b0;
    i_EMU_RST_n = 1'b0; i_EMU_CLK6MPCEN_n = 1'b1;
    {i_ABS_4H, i_ABS_2H, i_ABS_1H} = 3'd0;
    i_ROM_ACK = 1'b0; i_ROM_DATA = 32'h0;
`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
    i_UNDERRUN_CLR = 1'b0;
`endif
    vecs[0] = '{1'b1, 3'd0, 3'd0, 12'h123, 12'h0AB, 3'd5, 3'd2, 15'h091D, 15'h055A, 16'hAAAB, 16'hABAA};
    vecs[1] = '{1'b1, 3'd5, 3'd6, 12'h7FF, 12'h800, 3'd0, 3'd7, 15'h3FF8, 15'h4007, 16'hAEAA, 16'hAABA};
    vecs[2] = '{1'b1, 3'd7, 3'd7, 12'h001, 12'hFFF, 3'd1, 3'd3, 15'h0009, 15'h7FFB, 16'hEAAA, 16'hAAEA};
    vecs[3] = '{1'b0, 3'd0, 3'd0, 12'h555, 12'h2AA, 3'd4, 3'd6, 15'h0000, 15'h0000, 16'h0000, 16'h0000};
    applyStimulus(vecs[0]);

    repeat (2) @(posedge i_EMU_MCLK);
    #1;
    checkOutput("reset ROM_REQ", o_ROM_REQ, 0);
    checkOutput("reset ROM_ADDR", o_ROM_ADDR, 0);
    checkOutput("reset GFXDATA", o_GFXDATA, 0);
    checkOutput("reset modes/flips", {o_A_MODE, o_B_MODE, o_AFF, o_BFF, o_UNDERRUN}, 0);
`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
    checkOutput("reset UNDERRUN_CNT", o_UNDERRUN_CNT, 0);
`endif
    i_EMU_RST_n = 1'b1;
    repeat (2) tick(1'b0);

    for (int e = 0; e < 4; e++) begin
      applyStimulus(vecs[e]);
      for (int p = 0; p < 8; p++) begin
        pixel();
        checkOutput($sformatf("vec%0d P%0d A_MODE", e, p), o_A_MODE, vecs[e].expAModes[p*2 +: 2]);
        checkOutput($sformatf("vec%0d P%0d B_MODE", e, p), o_B_MODE, vecs[e].expBModes[p*2 +: 2]);
        if (vecs[e].dispEn) begin
          if (p == 0) begin
            checkOutput($sformatf("vec%0d B REQ", e), o_ROM_REQ, 1);
            checkOutput($sformatf("vec%0d B ADDR", e), o_ROM_ADDR, vecs[e].expBAddr);
          end else if (p == 4) begin
            checkOutput($sformatf("vec%0d A REQ", e), o_ROM_REQ, 1);
            checkOutput($sformatf("vec%0d A ADDR", e), o_ROM_ADDR, vecs[e].expAAddr);
          end else if (p == 3) begin
            checkOutput($sformatf("vec%0d B GFX", e), o_GFXDATA, romWord(vecs[e].expBAddr));
          end else if (p == 7) begin
            checkOutput($sformatf("vec%0d A GFX", e), o_GFXDATA, romWord(vecs[e].expAAddr));
          end
        end else if (p == 0 || p == 4) begin
          checkOutput($sformatf("vec%0d no REQ when disabled", e), o_ROM_REQ, 0);
        end
      end
    end

    // B ack withheld: abort at P=3, A still fetches.
    applyStimulus(vecs[0]);
    suppressAck = 1'b1;
    repeat (3) pixel();
    checkOutput("underrun REQ held", o_ROM_REQ, 1);
    repeat (3) tick(1'b0);
    tick(1'b1);
    curP++;
    checkOutput("underrun GFX zero", o_GFXDATA, 0);
    checkOutput("underrun pulse", o_UNDERRUN, 1);
    checkOutput("underrun REQ drop", o_ROM_REQ, 0);
    tick(1'b0);
    checkOutput("underrun pulse width", o_UNDERRUN, 0);
    suppressAck = 1'b0;
    pixel();
    checkOutput("after underrun A ADDR", o_ROM_ADDR, 15'h091D);
    repeat (3) pixel();
    checkOutput("after underrun A GFX", o_GFXDATA, romWord(15'h091D));

    // Ack on the same MCLK as the A deadline.
    repeat (4) pixel();
    suppressAck = 1'b1;
    repeat (3) pixel();
    checkOutput("coincide REQ held", o_ROM_REQ, 1);
    repeat (3) tick(1'b0);
    forceAck = 1'b1;
    tick(1'b1);
    forceAck = 1'b0;
    curP++;
    checkOutput("coincide GFX", o_GFXDATA, romWord(15'h091D));
    checkOutput("coincide no underrun", o_UNDERRUN, 0);
    checkOutput("coincide REQ drop", o_ROM_REQ, 0);
    tick(1'b0);
    checkOutput("coincide no late underrun", o_UNDERRUN, 0);
    suppressAck = 1'b0;

    // A H/V flip with scroll 3: flip row, flip tap on the next slot's load.
    i_A_TILECODE = 12'h3C1; i_A_ROW = 3'd2; i_A_VFLIP = 1'b1; i_A_HFLIP = 1'b1; i_A_HSCROLL = 3'd3;
    repeat (4) pixel();
    checkOutput("hflip slot1 P3 A_MODE", o_A_MODE, 2'b11);
    checkOutput("hflip slot1 P3 AFF", o_AFF, 0);
    pixel();
    checkOutput("vflip A ADDR", o_ROM_ADDR, 15'h1E0D);
    repeat (6) pixel();
    checkOutput("hflip slot2 P2 A_MODE", o_A_MODE, 2'b10);
    pixel();
    checkOutput("hflip slot2 P3 A_MODE", o_A_MODE, 2'b11);
    checkOutput("hflip slot2 P3 AFF", o_AFF, 1);
    pixel();
    checkOutput("hflip slot2 P4 A_MODE", o_A_MODE, 2'b01);
    repeat (3) pixel();

    // Reset while REQ_A is outstanding, then a stray ack.
    applyStimulus(vecs[0]);
    repeat (4) pixel();
    suppressAck = 1'b1;
    pixel();
    checkOutput("pre-reset REQ_A", o_ROM_REQ, 1);
    tick(1'b0);
    i_EMU_RST_n = 1'b0;
    #1;
    checkOutput("async reset REQ", o_ROM_REQ, 0);
    checkOutput("async reset ADDR", o_ROM_ADDR, 0);
    checkOutput("async reset GFX", o_GFXDATA, 0);
    checkOutput("async reset modes/flips", {o_A_MODE, o_B_MODE, o_AFF, o_BFF, o_UNDERRUN}, 0);
    repeat (2) tick(1'b0);
    i_EMU_RST_n = 1'b1;
    suppressAck = 1'b0;
    repeat (2) tick(1'b0);
    forceAck = 1'b1;
    tick(1'b0);
    forceAck = 1'b0;
    checkOutput("late ack GFX ignored", o_GFXDATA, 0);
    checkOutput("late ack REQ", o_ROM_REQ, 0);
    checkOutput("late ack underrun", o_UNDERRUN, 0);
    pixel();
    checkOutput("post-reset P5 A_MODE", o_A_MODE, 2'b10);
    repeat (2) pixel();
    checkOutput("post-reset P7 REQ", o_ROM_REQ, 0);
    pixel();
    checkOutput("resume B REQ", o_ROM_REQ, 1);
    checkOutput("resume B ADDR", o_ROM_ADDR, 15'h055A);
    checkOutput("resume P0 A_MODE", o_A_MODE, 2'b11);
    repeat (7) pixel();

`ifdef TILEMAP_SCHED_UNDERRUN_CNT_EN
    // Two aborts per slot; 150 slots saturate the counter.
    suppressAck = 1'b1;
    for (int s = 0; s < 150; s++) begin
      for (int p = 0; p < 8; p++) pixel();
    end
    checkOutput("counter saturates", o_UNDERRUN_CNT, 8'd255);
    repeat (3) pixel();
    repeat (3) tick(1'b0);
    i_UNDERRUN_CLR = 1'b1;
    tick(1'b1);
    i_UNDERRUN_CLR = 1'b0;
    curP++;
    checkOutput("clear with abort pulse", o_UNDERRUN, 1);
    checkOutput("clear beats increment", o_UNDERRUN_CNT, 8'd0);
    repeat (4) pixel();
    checkOutput("count after clear", o_UNDERRUN_CNT, 8'd1);
    suppressAck = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
